// File: rtl/ram_responder.sv
// ----------------------------------------------------------------------------
// ram_responder: single-port word RAM model answering memory_control requests
// with programmable wait states, error flagging and access counters. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_C    = 4'(LAT);
  localparam bit         ZERO_LAT = (LAT == 0);

  logic        pend_q, pend_d;
  logic [31:0] p_addr_q, p_addr_d;
  logic        p_wen_q, p_wen_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic [31:0] mem_q [DEPTH];

  logic          req;
  logic          illegal;
  logic          match;
  logic          done;
  logic [AW-1:0] idx;

  assign idx     = ramaddr[AW+1:2];
  assign req     = ramREN | ramWEN;
  assign illegal = req & ((ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                          ({2'b00, ramaddr[31:2]} >= 32'(DEPTH)));
  assign match   = pend_q & (p_addr_q == ramaddr) & (p_wen_q == ramWEN);
  assign done    = req & ~illegal & (ZERO_LAT | (match & (cnt_q == LAT_C)));

  always_comb begin
    ramstate = BUSY;
    if (!req)         ramstate = FREE;
    else if (illegal) ramstate = ERROR;
    else if (done)    ramstate = ACCESS;
  end

  assign ramload  = ((ramstate == ACCESS) && ramREN) ? mem_q[idx] : 32'd0;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

  always_comb begin
    pend_d     = pend_q;
    p_addr_d   = p_addr_q;
    p_wen_d    = p_wen_q;
    cnt_d      = cnt_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (done) begin
      pend_d = 1'b0;
      if (ramWEN) wr_count_d = wr_count_q + 32'd1;
      else        rd_count_d = rd_count_q + 32'd1;
    end else if (req && !illegal) begin
      if (match) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        // Any change of address or direction restarts the wait count.
        pend_d   = 1'b1;
        p_addr_d = ramaddr;
        p_wen_d  = ramWEN;
        cnt_d    = 4'd1;
      end
    end else begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q     <= 1'b0;
      p_addr_q   <= 32'd0;
      p_wen_q    <= 1'b0;
      cnt_q      <= 4'd0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      pend_q     <= pend_d;
      p_addr_q   <= p_addr_d;
      p_wen_q    <= p_wen_d;
      cnt_q      <= cnt_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Storage is deliberately outside reset; only a completed write touches it.
  always_ff @(posedge CLK) begin
    if (!RST && done && ramWEN) mem_q[idx] <= ramstore;
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ----------------------------------------------------------------------------
// tb_ram_responder: directed self-checking bench for ram_responder (LAT=2 and
// LAT=0 instances sharing one clock). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_responder;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen, ren0, wen0;
  logic [31:0] addr, store, addr0, store0;
  logic [31:0] load, load0, rdc, rdc0, wrc, wrc0;
  logic [1:0]  st, st0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_responder #(.LAT(2), .DEPTH(1024)) dut (
    .CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
    .ramstore(store), .ramload(load), .ramstate(st),
    .rd_count(rdc), .wr_count(wrc)
  );

  ram_responder #(.LAT(0), .DEPTH(1024)) dut0 (
    .CLK(clk), .RST(rst), .ramREN(ren0), .ramWEN(wen0), .ramaddr(addr0),
    .ramstore(store0), .ramload(load0), .ramstate(st0),
    .rd_count(rdc0), .wr_count(wrc0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; addr = a; store = d;
    #1;
  endtask

  task automatic drv0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren0 = r; wen0 = w; addr0 = a; store0 = d;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ren = 0; wen = 0; addr = 0; store = 0;
    ren0 = 0; wen0 = 0; addr0 = 0; store0 = 0;

    // 1. reset
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(st), 32'(FREE));
    chk("rst_load", load, 32'd0);
    chk("rst_rdc", rdc, 32'd0);
    chk("rst_wrc", wrc, 32'd0);
    chk("rst_state0", 32'(st0), 32'(FREE));
    chk("rst_wrc0", wrc0, 32'd0);

    // 2. write then read back at 0x40
    drv(0, 1, 32'h40, 32'hDEADBEEF);
    chk("wr_busy1", 32'(st), 32'(BUSY));
    step();
    chk("wr_busy2", 32'(st), 32'(BUSY));
    step();
    chk("wr_access", 32'(st), 32'(ACCESS));
    chk("wr_nocnt_yet", wrc, 32'd0);
    step();
    chk("wr_count", wrc, 32'd1);
    drv(1, 0, 32'h40, 32'h0);
    chk("rd_busy1", 32'(st), 32'(BUSY));
    chk("rd_busy_load", load, 32'd0);
    step();
    chk("rd_busy2", 32'(st), 32'(BUSY));
    step();
    chk("rd_access", 32'(st), 32'(ACCESS));
    chk("rd_data", load, 32'hDEADBEEF);
    step();
    drv(0, 0, 32'h0, 32'h0);
    chk("rd_count", rdc, 32'd1);
    chk("idle_free", 32'(st), 32'(FREE));

    // 3. address change while busy
    drv(1, 0, 32'h10, 32'h0);
    chk("sw_busy0", 32'(st), 32'(BUSY));
    step();
    drv(1, 0, 32'h14, 32'h0);
    chk("sw_busy1", 32'(st), 32'(BUSY));
    step();
    chk("sw_busy2", 32'(st), 32'(BUSY));
    step();
    chk("sw_access", 32'(st), 32'(ACCESS));
    step();
    drv(0, 0, 32'h0, 32'h0);
    chk("sw_rdc", rdc, 32'd2);

    // 4. illegal requests
    drv(1, 1, 32'h0, 32'h0);
    chk("ill_both", 32'(st), 32'(ERROR));
    step();
    drv(0, 1, 32'h42, 32'h12345678);
    chk("ill_unal", 32'(st), 32'(ERROR));
    step();
    chk("ill_unal_hold", 32'(st), 32'(ERROR));
    step();
    drv(1, 0, 32'h1000, 32'h0);
    chk("ill_range", 32'(st), 32'(ERROR));
    chk("ill_range_load", load, 32'd0);
    step();
    drv(0, 0, 32'h0, 32'h0);
    chk("ill_rdc", rdc, 32'd2);
    chk("ill_wrc", wrc, 32'd1);
    drv(1, 0, 32'h40, 32'h0);
    step(); step();
    chk("ill_mem_access", 32'(st), 32'(ACCESS));
    chk("ill_mem_intact", load, 32'hDEADBEEF);
    step();
    drv(0, 0, 32'h0, 32'h0);
    chk("ill_rdc2", rdc, 32'd3);

    // 5. LAT=0 streaming
    drv0(0, 1, 32'h4, 32'h0000A5A5);
    chk("z_wr_access", 32'(st0), 32'(ACCESS));
    step();
    drv0(1, 0, 32'h0, 32'h0);
    chk("z_rd0", 32'(st0), 32'(ACCESS));
    step();
    drv0(1, 0, 32'h4, 32'h0);
    chk("z_rd4", 32'(st0), 32'(ACCESS));
    chk("z_rd4_data", load0, 32'h0000A5A5);
    step();
    drv0(1, 0, 32'h8, 32'h0);
    chk("z_rd8", 32'(st0), 32'(ACCESS));
    step();
    drv0(0, 0, 32'h0, 32'h0);
    chk("z_rdc", rdc0, 32'd3);
    chk("z_wrc", wrc0, 32'd1);

    // 6. reset in the second busy cycle of a write
    drv(0, 1, 32'h80, 32'hCAFEF00D);
    chk("rw_busy1", 32'(st), 32'(BUSY));
    step();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    #1;
    chk("rw_post_rst_wrc", wrc, 32'd0);
    chk("rw_restart1", 32'(st), 32'(BUSY));
    step();
    chk("rw_restart2", 32'(st), 32'(BUSY));
    step();
    chk("rw_access", 32'(st), 32'(ACCESS));
    step();
    drv(1, 0, 32'h80, 32'h0);
    chk("rw_wrc", wrc, 32'd1);
    step(); step();
    chk("rw_rd_access", 32'(st), 32'(ACCESS));
    chk("rw_data", load, 32'hCAFEF00D);
    step();
    drv(0, 0, 32'h0, 32'h0);
    chk("rw_rdc", rdc, 32'd1);
    chk("rw_wrc_final", wrc, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
